// File: rtl/scope_pkg.sv
// Shared types and default geometry for the scope pixel scheduler.
package scope_pkg;

  localparam int unsigned H_RES_DEFAULT = 1280;
  localparam int unsigned V_RES_DEFAULT = 1024;
  localparam int unsigned X_W_DEFAULT   = 11;
  localparam int unsigned Y_W_DEFAULT   = 10;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SERVE
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the
// pointer moves past the winner whenever the grant is consumed (advance).
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N-1:0]                         req,
  input  logic                                 advance,
  output logic [N-1:0]                         grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] index,
  output logic                                 valid
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  int unsigned   pos;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && valid) begin
      ptr <= (index == IW'(N - 1)) ? '0 : index + IW'(1);
    end
  end

endmodule

// File: rtl/scope_pixel_scheduler.sv
// Shares the single frame-store write port between a frame-clear sweep and
// NUM_CH trace channels, granted round-robin one pixel per accepted beat.
module scope_pixel_scheduler
  import scope_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned H_RES  = H_RES_DEFAULT,
  parameter int unsigned V_RES  = V_RES_DEFAULT,
  parameter int unsigned X_W    = X_W_DEFAULT,
  parameter int unsigned Y_W    = Y_W_DEFAULT,
  parameter rgb_t        BG_RGB = 24'h000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH*X_W-1:0] ch_x,
  input  logic [NUM_CH*Y_W-1:0] ch_y,
  input  logic [NUM_CH*24-1:0]  ch_rgb,
  output logic [NUM_CH-1:0]     ch_ack,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [X_W-1:0]        pix_x,
  output logic [Y_W-1:0]        pix_y,
  output rgb_t                  pix_rgb,
  output logic                  clearing
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sched_state_t    state;
  logic [X_W-1:0]  cx;
  logic [Y_W-1:0]  cy;
  logic [NUM_CH-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            gvalid;
  logic [X_W-1:0]  gx;
  logic [Y_W-1:0]  gy;
  rgb_t            grgb;
  logic            load_ok;
  logic            in_range;
  logic            take;
  logic            clr_load;
  logic            cx_last;
  logic            cy_last;

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (ch_req),
    .advance(take),
    .grant  (grant),
    .index  (gidx),
    .valid  (gvalid)
  );

  always_comb begin
    load_ok  = !pix_valid || pix_ready;
    gx       = ch_x[gidx*X_W +: X_W];
    gy       = ch_y[gidx*Y_W +: Y_W];
    grgb     = ch_rgb[gidx*24 +: 24];
    in_range = (gx < X_W'(H_RES)) && (gy < Y_W'(V_RES));
    // Out-of-range pixels are consumed even while the output is stalled.
    take     = (state == SERVE) && !frame_start && gvalid && (!in_range || load_ok);
    clr_load = (state == CLEAR) && !frame_start && load_ok;
    cx_last  = (cx == X_W'(H_RES - 1));
    cy_last  = (cy == Y_W'(V_RES - 1));
    ch_ack   = take ? grant : '0;
    clearing = (state == CLEAR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      if (frame_start) begin
        state <= CLEAR;
        cx    <= '0;
        cy    <= '0;
      end else if (clr_load) begin
        if (cx_last) begin
          cx <= '0;
          if (cy_last) begin
            cy    <= '0;
            state <= SERVE;
          end else begin
            cy <= cy + Y_W'(1);
          end
        end else begin
          cx <= cx + X_W'(1);
        end
      end

      if (clr_load) begin
        pix_valid <= 1'b1;
        pix_x     <= cx;
        pix_y     <= cy;
        pix_rgb   <= BG_RGB;
      end else if (take && in_range) begin
        pix_valid <= 1'b1;
        pix_x     <= gx;
        pix_y     <= gy;
        pix_rgb   <= grgb;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scope_pixel_scheduler.sv
// Directed + randomized bench for scope_pixel_scheduler on an 8x4 frame, 4 channels.
module tb_scope_pixel_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned HR  = 8;
  localparam int unsigned VR  = 4;
  localparam int unsigned XW  = 4;
  localparam int unsigned YW  = 3;
  localparam logic [23:0] BG  = 24'h0A0B0C;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_start;
  logic [NCH-1:0]    ch_req;
  logic [NCH*XW-1:0] ch_x;
  logic [NCH*YW-1:0] ch_y;
  logic [NCH*24-1:0] ch_rgb;
  logic [NCH-1:0]    ch_ack;
  logic              pix_valid;
  logic              pix_ready;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;
  logic [23:0]       pix_rgb;
  logic              clearing;

  int total = 0;
  int bad   = 0;

  // Reference model: expected output register contents and rr pointer.
  int          m_ptr;
  logic        m_valid;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [23:0] m_rgb;

  logic [XW-1:0] dx[NCH];
  logic [YW-1:0] dy[NCH];
  logic [23:0]   drgb[NCH];

  scope_pixel_scheduler #(
    .NUM_CH(NCH),
    .H_RES (HR),
    .V_RES (VR),
    .X_W   (XW),
    .Y_W   (YW),
    .BG_RGB(BG)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .ch_req     (ch_req),
    .ch_x       (ch_x),
    .ch_y       (ch_y),
    .ch_rgb     (ch_rgb),
    .ch_ack     (ch_ack),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .clearing   (clearing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int i = 0; i < NCH; i++) begin
      ch_x[i*XW +: XW]   = dx[i];
      ch_y[i*YW +: YW]   = dy[i];
      ch_rgb[i*24 +: 24] = drgb[i];
    end
  endtask

  task automatic rand_data(input int oor);
    for (int i = 0; i < NCH; i++) begin
      dx[i]   = (oor != 0) ? XW'($urandom_range(0, HR + 1)) : XW'($urandom_range(0, HR - 1));
      dy[i]   = (oor != 0) ? YW'($urandom_range(0, VR)) : YW'($urandom_range(0, VR - 1));
      drgb[i] = 24'($urandom);
    end
  endtask

  // Observes clear beats 0..nbeats-1 in raster order with pix_ready held high.
  task automatic run_clear(input int nbeats);
    int k = 0;
    int guard = 0;
    while (k < nbeats && guard < 80) begin
      tick();
      frame_start = 1'b0;
      pix_ready   = 1'b1;
      ch_req      = (k < HR * VR - 1) ? NCH'($urandom) : '0;
      rand_data(1);
      drive_data();
      #1;
      guard++;
      chk("clr_ack", 32'(ch_ack), 32'h0);
      if (pix_valid) begin
        chk("clr_x", 32'(pix_x), 32'(k % HR));
        chk("clr_y", 32'(pix_y), 32'(k / HR));
        chk("clr_rgb", 32'(pix_rgb), 32'(BG));
        chk("clr_flag", 32'(clearing), (k == HR * VR - 1) ? 32'h0 : 32'h1);
        k++;
      end
    end
    if (k < nbeats) chk("clr_timeout", 32'(k), 32'(nbeats));
  endtask

  // One SERVE cycle: checks the output register and ack against the model.
  task automatic serve_cycle(input logic [NCH-1:0] req, input logic rdy);
    int   w;
    logic ok;
    logic inr;
    logic [NCH-1:0] eack;
    tick();
    frame_start = 1'b0;
    ch_req      = req;
    pix_ready   = rdy;
    drive_data();
    #1;
    chk("pix_valid", 32'(pix_valid), 32'(m_valid));
    if (m_valid) begin
      chk("pix_x", 32'(pix_x), 32'(m_x));
      chk("pix_y", 32'(pix_y), 32'(m_y));
      chk("pix_rgb", 32'(pix_rgb), 32'(m_rgb));
    end
    w = -1;
    for (int k = 0; k < NCH; k++) begin
      if (w < 0 && req[(m_ptr + k) % NCH]) w = (m_ptr + k) % NCH;
    end
    ok   = !m_valid || rdy;
    eack = '0;
    if (w >= 0) begin
      inr = (int'(dx[w]) < HR) && (int'(dy[w]) < VR);
      if (!inr || ok) begin
        eack[w] = 1'b1;
        m_ptr   = (w + 1) % NCH;
      end
      if (inr && ok) begin
        m_valid = 1'b1;
        m_x     = dx[w];
        m_y     = dy[w];
        m_rgb   = drgb[w];
      end else if (rdy) begin
        m_valid = 1'b0;
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    chk("ch_ack", 32'(ch_ack), 32'(eack));
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    ch_req      = '0;
    pix_ready   = 1'b1;
    rand_data(0);
    drive_data();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_x     = '0;
    m_y     = '0;
    m_rgb   = '0;

    // Reset state and IDLE behaviour
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(pix_valid), 32'h0);
    chk("rst_x", 32'(pix_x), 32'h0);
    chk("rst_y", 32'(pix_y), 32'h0);
    chk("rst_rgb", 32'(pix_rgb), 32'h0);
    chk("rst_clearing", 32'(clearing), 32'h0);
    tick();
    ch_req = 4'hF;
    #1;
    chk("idle_ack", 32'(ch_ack), 32'h0);

    // Full clear sweep
    tick();
    frame_start = 1'b1;
    ch_req      = '0;
    #1;
    run_clear(HR * VR);
    m_valid = 1'b0;

    // Round-robin with all channels requesting
    for (int i = 0; i < 6; i++) begin
      rand_data(0);
      serve_cycle(4'hF, 1'b1);
    end
    serve_cycle(4'h0, 1'b1);

    // Backpressure with ch1 requesting
    rand_data(0);
    serve_cycle(4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) serve_cycle(4'b0010, 1'b0);
    serve_cycle(4'b0010, 1'b1);
    serve_cycle(4'h0, 1'b1);

    // Out-of-range drop on ch2, then ch3 wins next
    rand_data(0);
    dx[2] = XW'(HR);
    dy[2] = '0;
    serve_cycle(4'b0100, 1'b1);
    rand_data(0);
    serve_cycle(4'hF, 1'b1);

    // Randomized traffic including stalls and out-of-range pixels
    for (int i = 0; i < 200; i++) begin
      rand_data(1);
      serve_cycle(NCH'($urandom), ($urandom_range(0, 3) != 0));
    end
    serve_cycle(4'h0, 1'b1);
    serve_cycle(4'h0, 1'b1);

    // Restart mid-clear with a stalled in-flight beat
    tick();
    frame_start = 1'b1;
    ch_req      = '0;
    #1;
    run_clear(11);
    frame_start = 1'b1;
    pix_ready   = 1'b0;
    ch_req      = '0;
    #1;
    chk("fs_ack", 32'(ch_ack), 32'h0);
    tick();
    frame_start = 1'b0;
    pix_ready   = 1'b1;
    #1;
    chk("fs_hold_valid", 32'(pix_valid), 32'h1);
    chk("fs_hold_x", 32'(pix_x), 32'd2);
    chk("fs_hold_y", 32'(pix_y), 32'd1);
    run_clear(HR * VR);
    m_valid = 1'b0;
    rand_data(0);
    serve_cycle(4'hF, 1'b1);

    // Reset mid-SERVE with a valid beat
    tick();
    reset     = 1'b1;
    ch_req    = 4'hF;
    pix_ready = 1'b0;
    #1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(pix_valid), 32'h0);
    chk("mid_rst_x", 32'(pix_x), 32'h0);
    chk("mid_rst_y", 32'(pix_y), 32'h0);
    chk("mid_rst_rgb", 32'(pix_rgb), 32'h0);
    chk("mid_rst_ack", 32'(ch_ack), 32'h0);
    chk("mid_rst_clearing", 32'(clearing), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      ch_req    = 4'hF;
      pix_ready = 1'b1;
      #1;
      chk("post_rst_ack", 32'(ch_ack), 32'h0);
      chk("post_rst_valid", 32'(pix_valid), 32'h0);
    end
    tick();
    frame_start = 1'b1;
    ch_req      = '0;
    #1;
    run_clear(HR * VR);
    m_ptr   = 0;
    m_valid = 1'b0;
    rand_data(0);
    serve_cycle(4'hF, 1'b1);
    serve_cycle(4'hF, 1'b1);
    serve_cycle(4'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
